// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: collects 10-bit command words from MOSI
// and, on a read-data frame, shifts the RAM's read byte back out on MISO MSB-first.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int WORD_W   = ADDR_SIZE + 2;
  localparam int CNT_W    = $clog2(WORD_W + 1);
  localparam int TX_CNT_W = $clog2(ADDR_SIZE);

  localparam logic [CNT_W-1:0]    FIRST_BIT = CNT_W'(1);
  localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]    WORD_END  = CNT_W'(WORD_W);
  localparam logic [TX_CNT_W-1:0] TX_LAST   = TX_CNT_W'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]     bit_cnt;
  logic [WORD_W-2:0]    rx_shift;
  logic                 rd_addr_done;
  logic                 wait_tx;
  logic                 tx_busy;
  logic [ADDR_SIZE-2:0] tx_shift;
  logic [TX_CNT_W-1:0]  tx_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!SS_n) next_state = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (rd_addr_done) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // rx_shift holds the first nine bits; the tenth comes straight from MOSI into rx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_done <= 1'b0;
      wait_tx      <= 1'b0;
      tx_busy      <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE && SS_n) begin
        bit_cnt <= '0;
        wait_tx <= 1'b0;
        tx_busy <= 1'b0;
        MISO    <= 1'b0;
      end else begin
        case (state)
          CHK_CMD: begin
            rx_shift <= {{(WORD_W-2){1'b0}}, MOSI};
            bit_cnt  <= FIRST_BIT;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt != WORD_END) begin
              rx_shift <= {rx_shift[WORD_W-3:0], MOSI};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= {rx_shift, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD) rd_addr_done <= 1'b1;
                if (state == READ_DATA) begin
                  rd_addr_done <= 1'b0;
                  wait_tx      <= 1'b1;
                end
              end
            end
            // Byte goes out MSB first: bit 7 on the capture edge, one bit per edge after.
            if (state == READ_DATA) begin
              if (wait_tx && tx_valid) begin
                MISO     <= tx_data[ADDR_SIZE-1];
                tx_shift <= tx_data[ADDR_SIZE-2:0];
                tx_cnt   <= TX_LAST;
                wait_tx  <= 1'b0;
                tx_busy  <= 1'b1;
              end else if (tx_busy) begin
                if (tx_cnt != '0) begin
                  MISO     <= tx_shift[ADDR_SIZE-2];
                  tx_shift <= {tx_shift[ADDR_SIZE-3:0], 1'b0};
                  tx_cnt   <= tx_cnt - 1'b1;
                end else begin
                  MISO    <= 1'b0;
                  tx_busy <= 1'b0;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if: inputs change and outputs are sampled
// on the falling clock edge, frames are hand-encoded command words.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int miso_high_cnt = 0;
  logic [7:0] exp_byte;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .SS_n(SS_n),
    .MOSI(MOSI),
    .MISO(MISO),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and tally rx_valid pulses and MISO highs seen there.
  task automatic step();
    @(negedge clk);
    if (rx_valid === 1'b1) pulse_cnt++;
    if (MISO === 1'b1) miso_high_cnt++;
  endtask

  // One IDLE edge with SS_n low, then nbits of the word MSB first; ends one edge after the last bit.
  task automatic applyStimulus(input logic [9:0] word, input int nbits);
    SS_n = 1'b0;
    MOSI = 1'b0;
    step();
    for (int i = 0; i < nbits; i++) begin
      MOSI = word[9-i];
      step();
    end
  endtask

  task automatic endFrame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    step();
    step();
  endtask

  task automatic pulseTx(input logic [7:0] data);
    tx_data  = data;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  initial begin
    rst_n    = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_miso", MISO, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("[TB] write address frame");
    pulse_cnt = 0;
    miso_high_cnt = 0;
    applyStimulus(10'h0A5, 10);
    checkOutput("wa_rx_valid", rx_valid, 1);
    checkOutput("wa_rx_data", rx_data, 10'h0A5);
    step();
    checkOutput("wa_rx_valid_clear", rx_valid, 0);
    endFrame();
    checkOutput("wa_pulses", pulse_cnt, 1);
    checkOutput("wa_miso_quiet", miso_high_cnt, 0);

    $display("[TB] write data frame with trailing bits");
    pulse_cnt = 0;
    applyStimulus(10'h15A, 10);
    checkOutput("wd_rx_valid", rx_valid, 1);
    checkOutput("wd_rx_data", rx_data, 10'h15A);
    MOSI = 1'b1;
    step();
    step();
    step();
    endFrame();
    checkOutput("wd_pulses", pulse_cnt, 1);
    checkOutput("wd_rx_data_hold", rx_data, 10'h15A);

    $display("[TB] read address then read data");
    applyStimulus(10'h2A5, 10);
    checkOutput("ra_rx_valid", rx_valid, 1);
    checkOutput("ra_rx_data", rx_data, 10'h2A5);
    endFrame();
    applyStimulus(10'h300, 10);
    checkOutput("rd_rx_valid", rx_valid, 1);
    checkOutput("rd_rx_data", rx_data, 10'h300);
    step();
    pulseTx(8'hC3);
    exp_byte = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("rd_miso_bit%0d", 7 - i), MISO, exp_byte[7-i]);
      step();
    end
    checkOutput("rd_miso_after", MISO, 0);
    endFrame();

    $display("[TB] third read frame is a read address");
    applyStimulus(10'h301, 10);
    checkOutput("r3_rx_data", rx_data, 10'h301);
    step();
    miso_high_cnt = 0;
    pulseTx(8'hFF);
    for (int i = 0; i < 8; i++) step();
    checkOutput("r3_miso_quiet", miso_high_cnt, 0);
    endFrame();

    $display("[TB] aborted write frame");
    pulse_cnt = 0;
    applyStimulus(10'h0FF, 5);
    endFrame();
    checkOutput("ab_pulses", pulse_cnt, 0);
    checkOutput("ab_rx_data_hold", rx_data, 10'h301);
    applyStimulus(10'h155, 10);
    checkOutput("ab_next_rx_valid", rx_valid, 1);
    checkOutput("ab_next_rx_data", rx_data, 10'h155);
    endFrame();

    $display("[TB] aborted read data before tx_valid");
    applyStimulus(10'h3AA, 10);
    checkOutput("ard_rx_valid", rx_valid, 1);
    checkOutput("ard_rx_data", rx_data, 10'h3AA);
    SS_n = 1'b1;
    step();
    miso_high_cnt = 0;
    pulseTx(8'hFF);
    for (int i = 0; i < 9; i++) step();
    checkOutput("ard_miso_quiet", miso_high_cnt, 0);

    $display("[TB] reset during MISO transmission");
    applyStimulus(10'h2A5, 10);
    endFrame();
    applyStimulus(10'h3C3, 10);
    checkOutput("rst_pre_rx_data", rx_data, 10'h3C3);
    step();
    pulseTx(8'hC3);
    checkOutput("rst_pre_miso", MISO, 1);
    #2 rst_n = 1'b0;
    SS_n = 1'b1;
    #1;
    checkOutput("rst_mid_miso", MISO, 0);
    checkOutput("rst_mid_rx_valid", rx_valid, 0);
    checkOutput("rst_mid_rx_data", rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("[TB] read frame after reset is a read address");
    applyStimulus(10'h3C3, 10);
    checkOutput("pr_rx_data", rx_data, 10'h3C3);
    step();
    miso_high_cnt = 0;
    pulseTx(8'hFF);
    for (int i = 0; i < 8; i++) step();
    checkOutput("pr_miso_quiet", miso_high_cnt, 0);
    endFrame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
